// File: rtl/coin_event_conditioner.sv
// coin_event_conditioner: sync, debounce and serialize P/R/N/D panel presses into one-hot event pulses
module coin_event_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] sw_raw,
  output logic [3:0] ev,
  output logic [3:0] stable,
  output logic       busy,
  output logic       overflow
);
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] GAP = 4'(GAP_CYCLES);
  logic [3:0] pad_q, meta_q, sync_q, pending, press, sel;
  logic [7:0] cnt [4];
  logic [3:0] gap;
  logic fire;
  always_comb begin
    for (int i = 0; i < 4; i++) press[i] = sync_q[i] & ~stable[i] & (cnt[i] == LAST);
    fire = en & (gap == 4'd0) & (|pending);
    sel = !fire ? 4'b0000 :
          pending[2] ? 4'b0100 :
          pending[3] ? 4'b1000 :
          pending[0] ? 4'b0001 : 4'b0010;
    busy = (|pending) | (|gap);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pad_q <= '0;
      meta_q <= '0;
      sync_q <= '0;
      stable <= '0;
      pending <= '0;
      ev <= '0;
      overflow <= 1'b0;
      gap <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      pad_q <= sw_raw;
      meta_q <= pad_q;
      sync_q <= meta_q;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= (sync_q[i] == stable[i] || cnt[i] == LAST) ? 8'd0 : cnt[i] + 8'd1;
        stable[i] <= (cnt[i] == LAST) ? sync_q[i] : stable[i];
      end
      pending <= (pending & ~sel) | press;
      overflow <= |(press & pending & ~sel);
      ev <= sel;
      gap <= fire ? GAP : gap - {3'b000, |gap};
    end
  end
endmodule

// File: tb/tb_coin_event_conditioner.sv
// tb_coin_event_conditioner: directed scenario bench for coin_event_conditioner
module tb_coin_event_conditioner;
  logic clk = 1'b0;
  logic reset, en, en2;
  logic [3:0] sw, sw2, ev, stable, ev2, stable2;
  logic busy, ovf, busy2, ovf2;
  int errors = 0;
  int checks = 0;

  coin_event_conditioner dut (
    .clk(clk), .reset(reset), .en(en), .sw_raw(sw),
    .ev(ev), .stable(stable), .busy(busy), .overflow(ovf)
  );

  coin_event_conditioner #(.DEBOUNCE_CYCLES(2), .GAP_CYCLES(15)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .sw_raw(sw2),
    .ev(ev2), .stable(stable2), .busy(busy2), .overflow(ovf2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1; en2 = 1'b1; sw = '0; sw2 = '0;
    idle(3);
    checks++; if (ev !== 4'b0000) begin errors++; $display("FAIL reset_ev got=%b exp=0000", ev); end
    checks++; if (stable !== 4'b0000) begin errors++; $display("FAIL reset_stable got=%b exp=0000", stable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (busy2 !== 1'b0 || ev2 !== 4'b0000) begin errors++; $display("FAIL reset_dut2 busy=%b ev=%b exp 0/0000", busy2, ev2); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clean_press;
    int nz;
    logic [3:0] exp;
    sw = 4'b0001;
    for (int e = 0; e < 40; e++) begin
      tick();
      exp = (e == 19) ? 4'b0001 : 4'b0000;
      checks++; if (ev !== exp) begin errors++; $display("FAIL clean_ev edge=%0d got=%b exp=%b", e, ev, exp); end
      checks++; if (stable[0] !== (e >= 18)) begin errors++; $display("FAIL clean_stable edge=%0d got=%b exp=%b", e, stable[0], e >= 18); end
    end
    sw = 4'b0000;
    nz = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (ev !== 4'b0000) nz++;
    end
    checks++; if (nz !== 0) begin errors++; $display("FAIL clean_release events=%0d exp=0", nz); end
    checks++; if (stable !== 4'b0000) begin errors++; $display("FAIL clean_release_stable got=%b exp=0000", stable); end
  endtask

  task automatic test_bounce;
    int nz;
    logic [3:0] exp;
    nz = 0;
    for (int k = 0; k < 60; k++) begin
      sw = ((k / 5) % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
      if (ev !== 4'b0000) nz++;
    end
    checks++; if (nz !== 0) begin errors++; $display("FAIL bounce_events got=%0d exp=0", nz); end
    checks++; if (stable !== 4'b0000) begin errors++; $display("FAIL bounce_stable got=%b exp=0000", stable); end
    sw = 4'b0010;
    for (int e = 0; e < 31; e++) begin
      tick();
      exp = (e == 19) ? 4'b0010 : 4'b0000;
      checks++; if (ev !== exp) begin errors++; $display("FAIL bounce_ev edge=%0d got=%b exp=%b", e, ev, exp); end
    end
    sw = 4'b0000;
    idle(40);
  endtask

  task automatic test_simultaneous;
    logic [3:0] exp;
    sw = 4'b1111;
    for (int e = 0; e < 40; e++) begin
      tick();
      exp = (e == 19) ? 4'b0100 : (e == 22) ? 4'b1000 : (e == 25) ? 4'b0001 : (e == 28) ? 4'b0010 : 4'b0000;
      checks++; if (ev !== exp) begin errors++; $display("FAIL simul_ev edge=%0d got=%b exp=%b", e, ev, exp); end
      checks++; if (busy !== (e >= 18 && e <= 29)) begin errors++; $display("FAIL simul_busy edge=%0d got=%b exp=%b", e, busy, e >= 18 && e <= 29); end
    end
    sw = 4'b0000;
    idle(40);
  endtask

  task automatic test_enable_freeze;
    int nz;
    en = 1'b0;
    sw = 4'b0001;
    nz = 0;
    for (int e = 0; e < 50; e++) begin
      tick();
      if (ev !== 4'b0000) nz++;
    end
    checks++; if (nz !== 0) begin errors++; $display("FAIL freeze_events got=%0d exp=0", nz); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL freeze_busy got=%b exp=1", busy); end
    en = 1'b1;
    tick();
    checks++; if (ev !== 4'b0001) begin errors++; $display("FAIL freeze_release_ev got=%b exp=0001", ev); end
    tick();
    checks++; if (ev !== 4'b0000) begin errors++; $display("FAIL freeze_single_ev got=%b exp=0000", ev); end
    sw = 4'b0000;
    idle(40);
  endtask

  task automatic test_reset_mid;
    logic [3:0] exp;
    sw = 4'b1000;
    for (int e = 0; e < 19; e++) tick();
    checks++; if (busy !== 1'b1 || ev !== 4'b0000) begin errors++; $display("FAIL mid_pending busy=%b ev=%b exp 1/0000", busy, ev); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (ev !== 4'b0000) begin errors++; $display("FAIL mid_reset_ev got=%b exp=0000", ev); end
    checks++; if (stable !== 4'b0000) begin errors++; $display("FAIL mid_reset_stable got=%b exp=0000", stable); end
    checks++; if (busy !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL mid_reset_busy_ovf got=%b/%b exp=0/0", busy, ovf); end
    for (int e = 0; e < 26; e++) begin
      tick();
      exp = (e == 19) ? 4'b1000 : 4'b0000;
      checks++; if (ev !== exp) begin errors++; $display("FAIL mid_reaccept edge=%0d got=%b exp=%b", e, ev, exp); end
    end
    sw = 4'b0000;
    idle(40);
  endtask

  task automatic test_merge;
    int e, ovf_cnt, n_cnt, n_edge, other, ovf_edge;
    sw2 = 4'b0100;
    e = 0;
    tick();
    while (ev2 === 4'b0000 && e < 20) begin
      e++;
      tick();
    end
    checks++; if (e !== 5 || ev2 !== 4'b0100) begin errors++; $display("FAIL merge_r_ev edge=%0d ev=%b exp edge=5 ev=0100", e, ev2); end
    ovf_cnt = 0; n_cnt = 0; n_edge = -1; other = 0; ovf_edge = -1;
    for (int t = 1; t <= 30; t++) begin
      sw2 = (t <= 4 || t > 8) ? 4'b0110 : 4'b0100;
      tick();
      if (ovf2 === 1'b1) begin ovf_cnt++; ovf_edge = t; end
      if (ev2 === 4'b0010) begin n_cnt++; n_edge = t; end
      else if (ev2 !== 4'b0000) other++;
    end
    checks++; if (ovf_cnt !== 1) begin errors++; $display("FAIL merge_ovf_count got=%0d exp=1", ovf_cnt); end
    checks++; if (ovf_edge !== 13) begin errors++; $display("FAIL merge_ovf_edge got=%0d exp=13", ovf_edge); end
    checks++; if (n_cnt !== 1) begin errors++; $display("FAIL merge_n_count got=%0d exp=1", n_cnt); end
    checks++; if (n_edge !== 16) begin errors++; $display("FAIL merge_n_edge got=%0d exp=16", n_edge); end
    checks++; if (other !== 0) begin errors++; $display("FAIL merge_other_events got=%0d exp=0", other); end
    sw2 = 4'b0000;
    idle(30);
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL merge_idle_busy got=%b exp=0", busy2); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_enable_freeze();
    test_merge();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
